// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with same-cycle write bypass, a link-register
// write path, a registered PC-redirect pulse and a pending-write scoreboard.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   rd_addr_a/b, rd_data_a/b   two combinational read ports (with bypass)
//   rd_busy_a/b                operand has a pending write (stall request)
//   pc_val                     PC value returned on reads of PC_IDX
//   wr_en, wr_addr, wr_data    writeback port
//   link_en, link_data         return-address write into LR_IDX
//   claim_en, claim_addr       reserve a destination for a future write
//   claim_err                  registered pulse: claim hit a busy register
//   wr_to_pc, pc_wr_data       registered pulse + data for writes to PC_IDX
//   busy_cnt                   number of registers currently busy
module reg_file_sb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned PC_IDX = (2 ** ADDR_W) - 1,
    parameter int unsigned LR_IDX = (2 ** ADDR_W) - 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_busy_a,
    output logic              rd_busy_b,
    input  logic [DATA_W-1:0] pc_val,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              link_en,
    input  logic [DATA_W-1:0] link_data,
    input  logic              claim_en,
    input  logic [ADDR_W-1:0] claim_addr,
    output logic              claim_err,
    output logic              wr_to_pc,
    output logic [DATA_W-1:0] pc_wr_data,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;
    localparam int unsigned CNT_W    = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);
    localparam logic [ADDR_W-1:0] LR_A = ADDR_W'(LR_IDX);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    logic [CNT_W-1:0]    cnt_next;
    logic                claim_err_next;
    logic                pc_write;

    // Read priority: PC alias, then writeback bypass, then link bypass, then array.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] data;
        if (addr == PC_A)                  data = pc_val;
        else if (wr_en && wr_addr == addr) data = wr_data;
        else if (link_en && addr == LR_A)  data = link_data;
        else                               data = regs[addr];
        return data;
    endfunction

    always_comb begin
        rd_data_a = read_port(rd_addr_a);
        rd_data_b = read_port(rd_addr_b);
    end

    // A same-cycle writeback resolves the hazard through the bypass.
    assign rd_busy_a = busy[rd_addr_a] && !(wr_en && wr_addr == rd_addr_a) && (rd_addr_a != PC_A);
    assign rd_busy_b = busy[rd_addr_b] && !(wr_en && wr_addr == rd_addr_b) && (rd_addr_b != PC_A);

    assign pc_write = wr_en && (wr_addr == PC_A);

    // Next busy vector: write clears first, so a same-cycle claim re-sets it.
    always_comb begin
        busy_next = busy;
        if (wr_en) begin
            busy_next[wr_addr] = 1'b0;
        end
        if (claim_en && claim_addr != PC_A) begin
            busy_next[claim_addr] = 1'b1;
        end
        cnt_next = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            cnt_next = cnt_next + CNT_W'(busy_next[i]);
        end
        claim_err_next = claim_en && (claim_addr != PC_A) && busy[claim_addr]
                         && !(wr_en && wr_addr == claim_addr);
    end

    // State update; writeback is applied after link so wr_data wins on LR_IDX.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            busy       <= '0;
            busy_cnt   <= '0;
            claim_err  <= 1'b0;
            wr_to_pc   <= 1'b0;
            pc_wr_data <= '0;
        end else begin
            if (link_en) begin
                regs[LR_A] <= link_data;
            end
            if (wr_en && wr_addr != PC_A) begin
                regs[wr_addr] <= wr_data;
            end
            busy      <= busy_next;
            busy_cnt  <= cnt_next;
            claim_err <= claim_err_next;
            wr_to_pc  <= pc_write;
            if (pc_write) begin
                pc_wr_data <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Testbench for reg_file_sb: directed steps followed by random traffic,
// all checked against a behavioural reference model.
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  rd_addr_a, rd_addr_b;
    logic [31:0] rd_data_a, rd_data_b;
    logic        rd_busy_a, rd_busy_b;
    logic [31:0] pc_val;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        link_en;
    logic [31:0] link_data;
    logic        claim_en;
    logic [3:0]  claim_addr;
    logic        claim_err;
    logic        wr_to_pc;
    logic [31:0] pc_wr_data;
    logic [4:0]  busy_cnt;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state
    bit [31:0] m_regs [16];
    bit        m_busy [16];
    bit        m_cerr;
    bit        m_pc;
    bit [31:0] m_pc_data;

    reg_file_sb dut (
        .clk(clk), .reset(reset),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .rd_busy_a(rd_busy_a), .rd_busy_b(rd_busy_b),
        .pc_val(pc_val),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .link_en(link_en), .link_data(link_data),
        .claim_en(claim_en), .claim_addr(claim_addr),
        .claim_err(claim_err), .wr_to_pc(wr_to_pc),
        .pc_wr_data(pc_wr_data), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit [31:0] m_read(input bit [3:0] a);
        if (a == 4'd15)                  return pc_val;
        if (wr_en && wr_addr == a)       return wr_data;
        if (link_en && a == 4'd14)       return link_data;
        return m_regs[a];
    endfunction

    function automatic bit m_rdbusy(input bit [3:0] a);
        return (a != 4'd15) && m_busy[a] && !(wr_en && wr_addr == a);
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 16; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    // Apply the spec's edge rules to the model using the current inputs.
    task automatic model_edge();
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end
            m_cerr = 0; m_pc = 0; m_pc_data = '0;
        end else begin
            m_cerr = claim_en && claim_addr != 4'd15 && m_busy[claim_addr]
                     && !(wr_en && wr_addr == claim_addr);
            m_pc = wr_en && wr_addr == 4'd15;
            if (m_pc) m_pc_data = wr_data;
            if (link_en) m_regs[14] = link_data;
            if (wr_en && wr_addr != 4'd15) m_regs[wr_addr] = wr_data;
            if (wr_en) m_busy[wr_addr] = 1'b0;
            if (claim_en && claim_addr != 4'd15) m_busy[claim_addr] = 1'b1;
        end
    endtask

    // One clock: check combinational outputs, advance, check registered outputs.
    task automatic cycle();
        bit was_reset;
        #1;
        check("rd_data_a", rd_data_a, m_read(rd_addr_a));
        check("rd_data_b", rd_data_b, m_read(rd_addr_b));
        check("rd_busy_a", rd_busy_a, m_rdbusy(rd_addr_a));
        check("rd_busy_b", rd_busy_b, m_rdbusy(rd_addr_b));
        was_reset = reset;
        model_edge();
        @(posedge clk);
        #1;
        reset = 0; wr_en = 0; link_en = 0; claim_en = 0;
        #1;
        check("claim_err", claim_err, m_cerr);
        check("wr_to_pc", wr_to_pc, m_pc);
        check("busy_cnt", busy_cnt, m_count());
        if (m_pc || was_reset) check("pc_wr_data", pc_wr_data, m_pc_data);
    endtask

    initial begin
        reset = 1; wr_en = 0; link_en = 0; claim_en = 0;
        rd_addr_a = 0; rd_addr_b = 0; pc_val = 0;
        wr_addr = 0; wr_data = 0; link_data = 0; claim_addr = 0;
        @(negedge clk);

        // Reset state
        cycle();
        check("rst_cnt", busy_cnt, 0);
        check("rst_rd_a", rd_data_a, 0);

        // Write with same-cycle bypass
        rd_addr_a = 3; wr_en = 1; wr_addr = 3; wr_data = 32'hAAAA_AAAA;
        #1 check("bypass_a", rd_data_a, 32'hAAAA_AAAA);
        cycle();
        check("stored_a", rd_data_a, 32'hAAAA_AAAA);

        // Write to PC alias
        rd_addr_b = 15; pc_val = 32'h100; wr_en = 1; wr_addr = 15; wr_data = 32'hCCCC_CCCC;
        #1 check("pc_read_b", rd_data_b, 32'h100);
        cycle();
        check("pc_pulse", wr_to_pc, 1);
        check("pc_data", pc_wr_data, 32'hCCCC_CCCC);
        check("pc_read_b2", rd_data_b, 32'h100);
        cycle();
        check("pc_pulse_end", wr_to_pc, 0);

        // Claim, clearing write, double claim
        claim_en = 1; claim_addr = 5;
        cycle();
        rd_addr_a = 5;
        #1 check("cnt_claim", busy_cnt, 1);
        check("busy_a_set", rd_busy_a, 1);
        wr_en = 1; wr_addr = 5; wr_data = 32'h55;
        #1 check("busy_a_bypass", rd_busy_a, 0);
        cycle();
        check("cnt_cleared", busy_cnt, 0);
        claim_en = 1; claim_addr = 5;
        cycle();
        check("claim_err_first", claim_err, 0);
        claim_en = 1; claim_addr = 5;
        cycle();
        check("claim_err_pulse", claim_err, 1);
        check("cnt_double", busy_cnt, 1);
        cycle();
        check("claim_err_end", claim_err, 0);

        // Link register
        link_en = 1; link_data = 32'h200; rd_addr_a = 14;
        cycle();
        check("link_store", rd_data_a, 32'h200);
        link_en = 1; link_data = 32'h300; wr_en = 1; wr_addr = 14; wr_data = 32'h77;
        #1 check("link_wr_bypass", rd_data_a, 32'h77);
        cycle();
        check("link_wr_wins", rd_data_a, 32'h77);

        // Same-cycle claim and write; claim to PC ignored
        claim_en = 1; claim_addr = 2; wr_en = 1; wr_addr = 2; wr_data = 32'h22;
        cycle();
        rd_addr_a = 2;
        #1 check("cw_data", rd_data_a, 32'h22);
        check("cw_busy", rd_busy_a, 1);
        check("cw_cnt", busy_cnt, 2);
        claim_en = 1; claim_addr = 15;
        cycle();
        check("pc_claim_cnt", busy_cnt, 2);

        // Reset overrides write, link, claim
        reset = 1; wr_en = 1; wr_addr = 15; wr_data = 32'h1234;
        link_en = 1; link_data = 32'h9; claim_en = 1; claim_addr = 9;
        cycle();
        check("rst_no_pc", wr_to_pc, 0);
        check("rst_cnt2", busy_cnt, 0);
        for (int i = 0; i < 15; i++) begin
            rd_addr_a = 4'(i);
            #1 check("rst_zero", rd_data_a, 0);
        end

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            reset      = ($urandom_range(63) == 0);
            rd_addr_a  = 4'($urandom_range(15));
            rd_addr_b  = 4'($urandom_range(15));
            pc_val     = $urandom;
            wr_en      = $urandom_range(1);
            wr_addr    = 4'($urandom_range(15));
            wr_data    = $urandom;
            link_en    = ($urandom_range(3) == 0);
            link_data  = $urandom;
            claim_en   = $urandom_range(1);
            claim_addr = 4'($urandom_range(15));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
